// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Runs a photobooth capture session once the UI screens are finished.
//   1. On go, the filter and threshold selections are latched.
//   2. A seconds countdown runs.
//   3. Exactly one camera frame is gated into the frame buffer.
//   4. The shot is handed to the filter pipeline with a start/done handshake.
//   5. Steps 2-4 repeat for NUM_SHOTS shots, then the block sits in DONE.
//
// Ports
//   clk_in                : pixel clock
//   rst_in                : asynchronous active-low reset
//   go_in / cancel_in     : session start / abort pulses from the UI
//   filter_select_in      : filter choice from the UI
//   threshold_select_in   : threshold choice from the UI
//   frame_start_in        : pulse at hcount=0, vcount=0
//   proc_done_in          : pulse from the filter pipeline
//   capture_we_out        : frame buffer write enable
//   proc_start_out        : start pulse to the filter pipeline
//   filter_cfg_out        : latched filter selection
//   threshold_cfg_out     : latched threshold selection
//   shot_idx_out          : current shot number
//   countdown_out         : seconds remaining
//   busy_out / done_out   : session status
//   flash_out             : present only with CAPTURE_FLASH_EN defined
//
// Optional feature (macro CAPTURE_FLASH_EN)
//   flash_out is high while the frame is being written, and during the
//   last countdown second.
//
// state      | meaning
// IDLE       | no session; waiting for go
// COUNTDOWN  | counting down seconds before a shot
// WAIT_FRAME | countdown over; waiting for the next frame start
// CAPTURE    | writing one full frame into the buffer
// PROCESS    | waiting for the filter pipeline to finish the shot
// DONE       | all shots processed; waiting for go or cancel

module capture_sequencer #(
  parameter int CYCLES_PER_SEC = 74250000,
  parameter int COUNT_SECS     = 3,
  parameter int NUM_SHOTS      = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       go_in,
  input  logic       cancel_in,
  input  logic [2:0] filter_select_in,
  input  logic [2:0] threshold_select_in,
  input  logic       frame_start_in,
  input  logic       proc_done_in,
  output logic       capture_we_out,
  output logic       proc_start_out,
  output logic [2:0] filter_cfg_out,
  output logic [2:0] threshold_cfg_out,
  output logic [2:0] shot_idx_out,
  output logic [3:0] countdown_out,
  output logic       busy_out,
  output logic       done_out
`ifdef CAPTURE_FLASH_EN
  ,
  output logic       flash_out
`endif
);

  localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_SEC - 1);
  localparam logic [3:0] CD_INIT = 4'(COUNT_SECS);
  localparam logic [2:0] LAST_SHOT = 3'(NUM_SHOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNTDOWN, S_WAIT_FRAME, S_CAPTURE, S_PROCESS, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sec_cnt, sec_cnt_nxt;
  logic             tick;
  logic             we_nxt, ps_nxt, busy_nxt, done_nxt;
  logic [2:0]       filt_nxt, thr_nxt, shot_nxt;
  logic [3:0]       cd_nxt;
  // cancel is meaningless in IDLE, so a go arriving with it there still starts
  logic             abort;
`ifdef CAPTURE_FLASH_EN
  logic             flash_nxt;
`endif

  assign tick  = (sec_cnt == CNT_MAX);
  assign abort = cancel_in && (state != S_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= S_IDLE;
      sec_cnt           <= '0;
      capture_we_out    <= 1'b0;
      proc_start_out    <= 1'b0;
      filter_cfg_out    <= 3'd0;
      threshold_cfg_out <= 3'd0;
      shot_idx_out      <= 3'd0;
      countdown_out     <= 4'd0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
`ifdef CAPTURE_FLASH_EN
      flash_out         <= 1'b0;
`endif
    end else begin
      state             <= state_nxt;
      sec_cnt           <= sec_cnt_nxt;
      capture_we_out    <= we_nxt;
      proc_start_out    <= ps_nxt;
      filter_cfg_out    <= filt_nxt;
      threshold_cfg_out <= thr_nxt;
      shot_idx_out      <= shot_nxt;
      countdown_out     <= cd_nxt;
      busy_out          <= busy_nxt;
      done_out          <= done_nxt;
`ifdef CAPTURE_FLASH_EN
      flash_out         <= flash_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (go_in) state_nxt = S_COUNTDOWN;
        // a frame start coinciding with the last tick is deliberately missed
        S_COUNTDOWN:    if (tick && countdown_out == 4'd1) state_nxt = S_WAIT_FRAME;
        S_WAIT_FRAME:   if (frame_start_in) state_nxt = S_CAPTURE;
        S_CAPTURE:      if (frame_start_in) state_nxt = S_PROCESS;
        S_PROCESS:      if (proc_done_in)
                          state_nxt = (shot_idx_out == LAST_SHOT) ? S_DONE : S_COUNTDOWN;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sec_cnt_nxt = sec_cnt;
    we_nxt      = capture_we_out;
    ps_nxt      = 1'b0;
    filt_nxt    = filter_cfg_out;
    thr_nxt     = threshold_cfg_out;
    shot_nxt    = shot_idx_out;
    cd_nxt      = countdown_out;
    if (abort) begin
      sec_cnt_nxt = '0;
      we_nxt      = 1'b0;
      shot_nxt    = 3'd0;
      cd_nxt      = 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go_in) begin
            filt_nxt    = filter_select_in;
            thr_nxt     = threshold_select_in;
            shot_nxt    = 3'd0;
            cd_nxt      = CD_INIT;
            sec_cnt_nxt = '0;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            sec_cnt_nxt = '0;
            cd_nxt      = countdown_out - 4'd1;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
        S_WAIT_FRAME: if (frame_start_in) we_nxt = 1'b1;
        S_CAPTURE: begin
          if (frame_start_in) begin
            we_nxt = 1'b0;
            ps_nxt = 1'b1;
          end
        end
        S_PROCESS: begin
          if (proc_done_in && shot_idx_out != LAST_SHOT) begin
            shot_nxt    = shot_idx_out + 3'd1;
            cd_nxt      = CD_INIT;
            sec_cnt_nxt = '0;
          end
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_nxt = (state_nxt == S_DONE);
`ifdef CAPTURE_FLASH_EN
    flash_nxt = we_nxt || (state_nxt == S_COUNTDOWN && cd_nxt == 4'd1);
`endif
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: CYCLES_PER_SEC=10, COUNT_SECS=3, NUM_SHOTS=4.
// Stimulus pushes the expected proc_start and done events into queues.
// A monitor pops and checks them when the DUT raises the matching output.
module tb_capture_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       go_in = 1'b0, cancel_in = 1'b0;
  logic [2:0] filter_select_in = 3'd0, threshold_select_in = 3'd0;
  logic       frame_start_in = 1'b0;
  logic       proc_done_in;
  logic       done_auto = 1'b0, done_manual = 1'b0;
  logic       capture_we_out, proc_start_out, busy_out, done_out;
  logic [2:0] filter_cfg_out, threshold_cfg_out, shot_idx_out;
  logic [3:0] countdown_out;

  assign proc_done_in = done_auto | done_manual;

  capture_sequencer #(.CYCLES_PER_SEC(10), .COUNT_SECS(3), .NUM_SHOTS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .go_in(go_in), .cancel_in(cancel_in),
    .filter_select_in(filter_select_in), .threshold_select_in(threshold_select_in),
    .frame_start_in(frame_start_in), .proc_done_in(proc_done_in),
    .capture_we_out(capture_we_out), .proc_start_out(proc_start_out),
    .filter_cfg_out(filter_cfg_out), .threshold_cfg_out(threshold_cfg_out),
    .shot_idx_out(shot_idx_out), .countdown_out(countdown_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [2:0] shot; logic [2:0] filt; logic [2:0] thr; } exp_t;
  exp_t exp_start[$];
  int   exp_done[$];
  int   n_cmp = 0, n_fail = 0, n_start = 0;
  logic resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // free-running frame timing, one frame_start every 50 cycles
  initial forever begin
    repeat (49) @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
  end

  // filter pipeline model: done 20 cycles after start
  initial forever begin
    @(negedge clk_in);
    if (proc_start_out && resp_en) begin
      repeat (19) @(negedge clk_in);
      done_auto = 1'b1;
      @(negedge clk_in);
      done_auto = 1'b0;
    end
  end

  // monitor
  initial begin
    int   we_len;
    logic prev_we, prev_done;
    exp_t e;
    int   ed;
    we_len = 0; prev_we = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (proc_start_out) begin
        n_start++;
        if (exp_start.size() == 0) begin
          chk("unexpected_proc_start", 1, 0);
        end else begin
          e = exp_start.pop_front();
          chk("start_shot_idx", shot_idx_out, e.shot);
          chk("start_filter_cfg", filter_cfg_out, e.filt);
          chk("start_threshold_cfg", threshold_cfg_out, e.thr);
          chk("we_frame_len", we_len, 50);
          chk("start_on_we_fall", {prev_we, capture_we_out}, 2'b10);
        end
        we_len = 0;
      end else if (!capture_we_out) begin
        we_len = 0;
      end
      if (capture_we_out) we_len++;
      if (done_out && !prev_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ed = exp_done.pop_front();
          chk("done_shot_idx", shot_idx_out, ed);
          chk("done_busy", busy_out, 0);
        end
      end
      prev_we = capture_we_out;
      prev_done = done_out;
    end
  end

  // which: 0 done_out, 1 shot1 capturing, 2 proc_start_out
  task automatic wait_cond(input int which, input int limit, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk_in);
      case (which)
        0: hit = done_out;
        1: hit = (shot_idx_out == 3'd1) && capture_we_out;
        default: hit = proc_start_out;
      endcase
    end
    if (!hit) chk(name, 0, 1);
  endtask

  task automatic start_go(input logic [2:0] f, input logic [2:0] t);
    go_in = 1'b1; filter_select_in = f; threshold_select_in = t;
    @(negedge clk_in);
    go_in = 1'b0; filter_select_in = 3'd0; threshold_select_in = 3'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, capture_we_out, 0);
    chk({tag, "_ps"}, proc_start_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_shot"}, shot_idx_out, 0);
    chk({tag, "_cd"}, countdown_out, 0);
    chk({tag, "_filt"}, filter_cfg_out, 0);
    chk({tag, "_thr"}, threshold_cfg_out, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_in = 1'b1;
    @(negedge clk_in);

    // session A: four shots
    for (int s = 0; s < 4; s++) exp_start.push_back('{3'(s), 3'd2, 3'd1});
    exp_done.push_back(3);
    start_go(3'd2, 3'd1);
    chk("go_filter_cfg", filter_cfg_out, 2);
    chk("go_threshold_cfg", threshold_cfg_out, 1);
    chk("go_countdown", countdown_out, 3);
    chk("go_busy", busy_out, 1);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_in);
      if (i == 5) begin
        go_in = 1'b1; filter_select_in = 3'd7; threshold_select_in = 3'd7;
      end
      if (i == 6) begin
        go_in = 1'b0; filter_select_in = 3'd0; threshold_select_in = 3'd0;
        chk("midgo_filter_cfg", filter_cfg_out, 2);
        chk("midgo_threshold_cfg", threshold_cfg_out, 1);
      end
      if (i == 9)  chk("cd_at_9", countdown_out, 3);
      if (i == 10) chk("cd_at_10", countdown_out, 2);
      if (i == 20) chk("cd_at_20", countdown_out, 1);
      if (i == 29) chk("cd_at_29", countdown_out, 1);
      if (i == 30) begin
        chk("cd_at_30", countdown_out, 0);
        chk("wait_frame_busy", busy_out, 1);
        chk("wait_frame_we", capture_we_out, 0);
      end
    end
    wait_cond(0, 2000, "timeout_session_done");
    chk("session_starts", n_start, 4);
    chk("session_done", done_out, 1);
    chk("session_busy", busy_out, 0);
    chk("session_queue_empty", exp_start.size(), 0);

    // session B from DONE, cancelled during the second shot's capture
    exp_start.push_back('{3'd0, 3'd4, 3'd3});
    start_go(3'd4, 3'd3);
    chk("restart_done_fall", done_out, 0);
    chk("restart_busy", busy_out, 1);
    chk("restart_filter_cfg", filter_cfg_out, 4);
    wait_cond(1, 500, "timeout_shot1_capture");
    repeat (10) @(negedge clk_in);
    cancel_in = 1'b1;
    @(negedge clk_in);
    cancel_in = 1'b0;
    chk("cancel_we", capture_we_out, 0);
    chk("cancel_shot", shot_idx_out, 0);
    chk("cancel_busy", busy_out, 0);
    chk("cancel_cd", countdown_out, 0);
    chk("cancel_keep_filter", filter_cfg_out, 4);
    chk("cancel_keep_threshold", threshold_cfg_out, 3);
    repeat (5) @(negedge clk_in);
    done_manual = 1'b1;
    @(negedge clk_in);
    done_manual = 1'b0;
    repeat (30) @(negedge clk_in);
    chk("stray_done_busy", busy_out, 0);
    chk("stray_done_done", done_out, 0);

    // session C: asynchronous reset while in PROCESS
    resp_en = 1'b0;
    exp_start.push_back('{3'd0, 3'd1, 3'd6});
    start_go(3'd1, 3'd6);
    wait_cond(2, 300, "timeout_proc_start_c");
    repeat (5) @(negedge clk_in);
    #3 rst_in = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    exp_start.push_back('{3'd0, 3'd3, 3'd2});
    start_go(3'd3, 3'd2);
    chk("fresh_filter_cfg", filter_cfg_out, 3);
    chk("fresh_threshold_cfg", threshold_cfg_out, 2);
    chk("fresh_cd", countdown_out, 3);
    wait_cond(2, 300, "timeout_proc_start_fresh");
    @(negedge clk_in);
    cancel_in = 1'b1; done_manual = 1'b1;
    @(negedge clk_in);
    cancel_in = 1'b0; done_manual = 1'b0;
    chk("cancel_vs_done_busy", busy_out, 0);
    chk("cancel_vs_done_shot", shot_idx_out, 0);
    repeat (3) @(negedge clk_in);
    chk("cancel_vs_done_idle", busy_out, 0);
    chk("final_start_queue", exp_start.size(), 0);
    chk("final_done_queue", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "global timeout");
  end

endmodule
